tdm_demux_rx: RTL and testbench

TDM_DEMUX_RX -- requirements
Module: tdm_demux_rx

---
 rtl/tdm_pkg.sv | 14 +
 rtl/tdm_demux_rx_if.sv | 32 +++
 rtl/tdm_chan_rx.sv | 97 +++++++++
 rtl/tdm_demux_rx.sv | 49 ++++
 tb/tb_tdm_demux_rx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and types for the 2:1 TDM serial demultiplexer receiver.
package tdm_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    typedef enum logic {
        StEmpty,
        StFull
    } hold_state_e;

endpackage

// File: rtl/tdm_demux_rx_if.sv
// Serial-line, handshake and status bundle between the TDM line driver and the receiver.
interface tdm_demux_rx_if
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             y;
    logic             select;
    logic             bit_valid;
    logic             sync;
    logic             ovf_clr;
    logic             a_ready;
    logic             b_ready;
    logic [WIDTH-1:0] a_word;
    logic [WIDTH-1:0] b_word;
    logic             a_valid;
    logic             b_valid;
    logic             a_ovf;
    logic             b_ovf;

    modport master (
        output y, select, bit_valid, sync, ovf_clr, a_ready, b_ready,
        input  a_word, b_word, a_valid, b_valid, a_ovf, b_ovf
    );

    modport slave (
        input  y, select, bit_valid, sync, ovf_clr, a_ready, b_ready,
        output a_word, b_word, a_valid, b_valid, a_ovf, b_ovf
    );

endinterface

// File: rtl/tdm_chan_rx.sv
// One receive channel: MSB-first deserializer, single-word holding register with
// EMPTY/FULL handshake FSM, and a sticky overflow flag for dropped words.
module tdm_chan_rx
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_y,
    input  logic             i_sync,
    input  logic             i_ovf_clr,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_word,
    output logic             o_valid,
    output logic             o_ovf
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] r_shreg;
    logic [CntW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_word;
    logic             r_ovf;
    hold_state_e      r_state;
    hold_state_e      w_state_next;

    logic             w_shift;
    logic             w_last;
    logic             w_load;
    logic             w_drop;
    logic [WIDTH-1:0] w_new_word;

    assign w_shift    = i_en & ~i_sync;
    assign w_last     = w_shift & (r_cnt == LastCnt);
    assign w_new_word = {r_shreg[WIDTH-2:0], i_y};
    // A completed word is taken if the holder is empty or being drained this same edge.
    assign w_load     = w_last & ((r_state == StEmpty) | i_ready);
    assign w_drop     = w_last & (r_state == StFull) & ~i_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || i_sync) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_shreg <= w_new_word;
            r_cnt   <= w_last ? '0 : r_cnt + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word <= '0;
        end else if (w_load) begin
            r_word <= w_new_word;
        end
    end

    // Overflow set wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StEmpty: if (w_last) w_state_next = StFull;
            StFull:  if (i_ready && !w_last) w_state_next = StEmpty;
            default: w_state_next = StEmpty;
        endcase
    end

    always_comb begin
        o_valid = 1'b0;
        if (r_state == StFull) o_valid = 1'b1;
    end

    assign o_word = r_word;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/tdm_demux_rx.sv
// 2:1 TDM receiver: steers each tagged serial bit into channel a or b and presents
// completed words through independent valid/ready holding registers.
module tdm_demux_rx
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input logic            clk,
    input logic            rst_n,
    tdm_demux_rx_if.slave  bus
);

    logic w_en_a;
    logic w_en_b;

    assign w_en_a = bus.bit_valid & (bus.select == CH_A);
    assign w_en_b = bus.bit_valid & (bus.select == CH_B);

    tdm_chan_rx #(
        .WIDTH (WIDTH)
    ) u_chan_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_en_a),
        .i_y       (bus.y),
        .i_sync    (bus.sync),
        .i_ovf_clr (bus.ovf_clr),
        .i_ready   (bus.a_ready),
        .o_word    (bus.a_word),
        .o_valid   (bus.a_valid),
        .o_ovf     (bus.a_ovf)
    );

    tdm_chan_rx #(
        .WIDTH (WIDTH)
    ) u_chan_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_en_b),
        .i_y       (bus.y),
        .i_sync    (bus.sync),
        .i_ovf_clr (bus.ovf_clr),
        .i_ready   (bus.b_ready),
        .o_word    (bus.b_word),
        .o_valid   (bus.b_valid),
        .o_ovf     (bus.b_ovf)
    );

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Bench for tdm_demux_rx: directed scenarios plus random traffic against a word-level model.
module tb_tdm_demux_rx;

    localparam int unsigned W    = 8;
    localparam int unsigned MASK = (1 << W) - 1;

    logic clk;
    logic rst_n;

    tdm_demux_rx_if #(.WIDTH(W)) bus ();

    tdm_demux_rx #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per channel: bits collected so far and their value, plus the holder.
    int unsigned m_cnt  [2];
    int unsigned m_acc  [2];
    int unsigned m_hold [2];
    bit          m_full [2];
    bit          m_ovf  [2];

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit ready [2];
        ready[0] = bus.a_ready;
        ready[1] = bus.b_ready;
        for (int ch = 0; ch < 2; ch++) begin
            bit done;
            int unsigned word;
            done = 1'b0;
            word = 0;
            if (!rst_n) begin
                m_cnt[ch]  = 0;
                m_acc[ch]  = 0;
                m_hold[ch] = 0;
                m_full[ch] = 1'b0;
                m_ovf[ch]  = 1'b0;
            end else begin
                if (bus.sync) begin
                    m_cnt[ch] = 0;
                    m_acc[ch] = 0;
                end else if (bus.bit_valid && (int'(bus.select) == ch)) begin
                    m_acc[ch] = (m_acc[ch] * 2 + int'(bus.y)) & MASK;
                    m_cnt[ch]++;
                    if (m_cnt[ch] == W) begin
                        done      = 1'b1;
                        word      = m_acc[ch];
                        m_cnt[ch] = 0;
                        m_acc[ch] = 0;
                    end
                end
                if (bus.ovf_clr) m_ovf[ch] = 1'b0;
                if (done) begin
                    if (!m_full[ch] || ready[ch]) begin
                        m_hold[ch] = word;
                        m_full[ch] = 1'b1;
                    end else begin
                        m_ovf[ch] = 1'b1;
                    end
                end else if (m_full[ch] && ready[ch]) begin
                    m_full[ch] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("a_word",  bus.a_word,  m_hold[0]);
        check("a_valid", bus.a_valid, m_full[0]);
        check("a_ovf",   bus.a_ovf,   m_ovf[0]);
        check("b_word",  bus.b_word,  m_hold[1]);
        check("b_valid", bus.b_valid, m_full[1]);
        check("b_ovf",   bus.b_ovf,   m_ovf[1]);
    endtask

    task automatic send_bit(input bit ch, input bit b);
        bus.bit_valid = 1'b1;
        bus.select    = ch;
        bus.y         = b;
        step();
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_word(input bit ch, input logic [W-1:0] word);
        for (int i = W - 1; i >= 0; i--) send_bit(ch, word[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        rst_n         = 1'b0;
        bus.y         = 1'b1;
        bus.select    = 1'b0;
        bus.bit_valid = 1'b1;
        bus.sync      = 1'b0;
        bus.ovf_clr   = 1'b0;
        bus.a_ready   = 1'b1;
        bus.b_ready   = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("rst_a_valid", bus.a_valid, 0);
        check("rst_b_valid", bus.b_valid, 0);
        check("rst_a_word",  bus.a_word,  0);
        bus.bit_valid = 1'b0;
        rst_n         = 1'b1;
        step();

        // Single word on a
        send_word(1'b0, 8'hA5);
        check("a5_word",  bus.a_word,  8'hA5);
        check("a5_valid", bus.a_valid, 1);
        check("a5_bvld",  bus.b_valid, 0);
        step();
        check("a5_drain", bus.a_valid, 0);

        // Interleaved a/b bits
        wa = 8'h3C;
        wb = 8'hC3;
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(1'b0, wa[i]);
            if (i == 0) begin
                check("il_a_valid", bus.a_valid, 1);
                check("il_b_early", bus.b_valid, 0);
            end
            send_bit(1'b1, wb[i]);
        end
        check("il_b_valid", bus.b_valid, 1);
        check("il_b_word",  bus.b_word,  8'hC3);
        check("il_a_word",  bus.a_word,  8'h3C);
        step();

        // Overflow on a with consumer stalled
        bus.a_ready = 1'b0;
        send_word(1'b0, 8'h11);
        send_word(1'b0, 8'h22);
        check("ovf_word", bus.a_word, 8'h11);
        check("ovf_set",  bus.a_ovf,  1);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        check("ovf_clr", bus.a_ovf, 0);
        bus.a_ready = 1'b1;
        step();
        check("ovf_drain", bus.a_valid, 0);

        // Sync aborts a partial word
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
        bus.sync = 1'b1;
        send_bit(1'b0, 1'b1);
        bus.sync = 1'b0;
        send_word(1'b0, 8'hF0);
        check("sync_word", bus.a_word, 8'hF0);
        step();

        // Reset mid-word with b pending
        bus.b_ready = 1'b0;
        send_word(1'b1, 8'h99);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
        rst_n = 1'b0;
        send_bit(1'b1, 1'b1);
        check("mrst_b_valid", bus.b_valid, 0);
        check("mrst_b_word",  bus.b_word,  0);
        check("mrst_a_word",  bus.a_word,  0);
        rst_n       = 1'b1;
        bus.b_ready = 1'b1;
        send_word(1'b1, 8'h81);
        check("mrst_new", bus.b_word, 8'h81);
        step();

        // Completion while FULL with ready in the same cycle
        bus.a_ready = 1'b0;
        send_word(1'b0, 8'h5A);
        wa = 8'h7E;
        for (int i = W - 1; i >= 1; i--) send_bit(1'b0, wa[i]);
        bus.a_ready = 1'b1;
        send_bit(1'b0, wa[0]);
        check("full_ld_word",  bus.a_word,  8'h7E);
        check("full_ld_valid", bus.a_valid, 1);
        check("full_ld_ovf",   bus.a_ovf,   0);
        step();

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            rst_n         = ($urandom_range(0, 199) != 0);
            bus.sync      = ($urandom_range(0, 59) == 0);
            bus.ovf_clr   = ($urandom_range(0, 24) == 0);
            bus.bit_valid = ($urandom_range(0, 3) != 0);
            bus.select    = 1'($urandom);
            bus.y         = 1'($urandom);
            bus.a_ready   = ($urandom_range(0, 9) < 4);
            bus.b_ready   = ($urandom_range(0, 9) < 4);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
